// File: rtl/pipe_stage_hs_pkg.sv
// Shared widths and helper types for the elastic pipeline stage.
// ID_EX_PAYLOAD_W sizes the ID/EX instance:
//   pc + rs1 + rs2 + rd_addr + rd_we + dec_info.
package pipe_stage_hs_pkg;

  localparam int unsigned REG_BUS_WIDTH      = 32;
  localparam int unsigned REG_ADDR_BUS_WIDTH = 5;
  localparam int unsigned DEC_INFO_BUS_WIDTH = 12;

  localparam int unsigned ID_EX_PAYLOAD_W =
    REG_BUS_WIDTH            // pc
    + 2 * REG_BUS_WIDTH      // rs1, rs2
    + REG_ADDR_BUS_WIDTH     // rd_addr
    + 1                      // rd_we
    + DEC_INFO_BUS_WIDTH;    // dec_info

  // Per-slot write controls; clr has priority over load.
  typedef struct packed {
    logic load;
    logic clr;
  } slot_ctrl_t;

  // Number of occupied slots.
  function automatic logic [1:0] occupancy(input logic m_v, input logic s_v);
    return {1'b0, m_v} + {1'b0, s_v};
  endfunction

endpackage

// File: rtl/pipe_stage_hs_slot.sv
// pipe_slot: one valid+data entry with sync active-high reset,
// clear (valid only) and enable-gated data load.
module pipe_slot
  import pipe_stage_hs_pkg::*;
#(
  parameter int unsigned        DATA_W  = 32,
  parameter logic [DATA_W-1:0]  RST_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  slot_ctrl_t        ctrl_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o
);

  logic              valid_d, valid_q;
  logic [DATA_W-1:0] data_d, data_q;

  // Next-state: clear drops the entry but keeps data; load captures data.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (ctrl_i.clr) begin
      valid_d = 1'b0;
    end else if (ctrl_i.load) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end
  end

  // Slot registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= RST_VAL;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/pipe_stage_hs.sv
// pipe_stage_hs: elastic valid/ready pipeline stage with flush.
// Optional feature macro: PIPE_SKID_EN adds a skid slot S so that
// in_ready_o is a pure register output. Without it a single slot M is
// used and in_ready_o depends combinationally on out_ready_i.
module pipe_stage_hs
  import pipe_stage_hs_pkg::*;
#(
  parameter int unsigned        DATA_W  = 32,
  parameter logic [DATA_W-1:0]  RST_VAL = {DATA_W{1'b0}}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [1:0]        count_o
);

  logic              m_valid;
  logic [DATA_W-1:0] m_data;
  logic [DATA_W-1:0] m_din;
  slot_ctrl_t        m_ctrl;
  logic              accept;
  logic              consume;

`ifdef PIPE_SKID_EN
  logic              s_valid;
  logic [DATA_W-1:0] s_data;
  slot_ctrl_t        s_ctrl;

  assign in_ready_o = !s_valid && !rst;
`else
  assign in_ready_o = !rst && (!m_valid || out_ready_i);
`endif

  assign accept  = in_valid_i && in_ready_o;
  assign consume = m_valid && out_ready_i;

  // Slot write control in priority order: flush, S->M refill, M load, S load.
  always_comb begin
    m_ctrl = '0;
    m_din  = in_data_i;
`ifdef PIPE_SKID_EN
    s_ctrl = '0;
`endif
    if (flush_i) begin
      m_ctrl.clr = 1'b1;
`ifdef PIPE_SKID_EN
      s_ctrl.clr = 1'b1;
    end else if (s_valid && consume) begin
      m_ctrl.load = 1'b1;
      m_din       = s_data;
      s_ctrl.clr  = 1'b1;
`endif
    end else if (!m_valid || consume) begin
      if (accept) begin
        m_ctrl.load = 1'b1;
      end else if (consume) begin
        m_ctrl.clr = 1'b1;
      end
`ifdef PIPE_SKID_EN
    end else if (accept) begin
      s_ctrl.load = 1'b1;
`endif
    end
  end

  pipe_slot #(
    .DATA_W  (DATA_W),
    .RST_VAL (RST_VAL)
  ) u_slot_m (
    .clk     (clk),
    .rst     (rst),
    .ctrl_i  (m_ctrl),
    .data_i  (m_din),
    .valid_o (m_valid),
    .data_o  (m_data)
  );

`ifdef PIPE_SKID_EN
  pipe_slot #(
    .DATA_W  (DATA_W),
    .RST_VAL (RST_VAL)
  ) u_slot_s (
    .clk     (clk),
    .rst     (rst),
    .ctrl_i  (s_ctrl),
    .data_i  (in_data_i),
    .valid_o (s_valid),
    .data_o  (s_data)
  );

  assign count_o = occupancy(m_valid, s_valid);
`else
  assign count_o = occupancy(m_valid, 1'b0);
`endif

  assign out_valid_o = m_valid;
  assign out_data_o  = m_data;

endmodule

// File: tb/tb_pipe_stage_hs.sv
// Bench for pipe_stage_hs: queue model of the stage plus directed
// literal checks; works with or without PIPE_SKID_EN.
module tb_pipe_stage_hs;

  localparam int unsigned       DW     = 32;
  localparam logic [DW-1:0]     TB_RST = 32'hDEAD_BEEF;
`ifdef PIPE_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush_i = 1'b0;
  logic          in_valid_i = 1'b0;
  logic          in_ready_o;
  logic [DW-1:0] in_data_i = '0;
  logic          out_valid_o;
  logic          out_ready_i = 1'b0;
  logic [DW-1:0] out_data_o;
  logic [1:0]    count_o;

  int errors = 0;
  int checks = 0;

  pipe_stage_hs #(.DATA_W(DW), .RST_VAL(TB_RST)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (flush_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_data_i   (in_data_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_data_o  (out_data_o),
    .count_o     (count_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: FIFO of held payloads, capacity 2 with skid, 1 without.
  logic [DW-1:0] q[$];
  bit started = 1'b0;

  function automatic bit model_ready();
    if (rst) return 1'b0;
    if (SKID) return q.size() < 2;
    return (q.size() == 0) || out_ready_i;
  endfunction

  always @(posedge clk) begin
    bit acc, con;
    acc = in_valid_i && model_ready();
    con = (q.size() != 0) && out_ready_i;
    if (rst) begin
      q.delete();
      started = 1'b1;
    end else if (flush_i) begin
      q.delete();
    end else begin
      if (con) void'(q.pop_front());
      if (acc) q.push_back(in_data_i);
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("m_out_valid", DW'(out_valid_o), DW'(q.size() != 0));
      chk("m_count", DW'(count_o), DW'(q.size()));
      chk("m_in_ready", DW'(in_ready_o), DW'(model_ready()));
      if (q.size() != 0) chk("m_out_data", out_data_o, q[0]);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset for two cycles.
    rst = 1'b1;
    step();
    step();
    chk("rst_out_valid", DW'(out_valid_o), 0);
    chk("rst_out_data", out_data_o, TB_RST);
    chk("rst_count", DW'(count_o), 0);
    chk("rst_in_ready", DW'(in_ready_o), 0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", DW'(in_ready_o), 1);

    // Back-to-back stream.
    out_ready_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid_i = 1'b1;
      in_data_i  = DW'(32'h11 + i);
      step();
      chk("stream_valid", DW'(out_valid_o), 1);
      chk("stream_data", out_data_o, DW'(32'h11 + i));
      chk("stream_count", DW'(count_o), 1);
    end
    in_valid_i = 1'b0;
    step();
    chk("stream_drain_count", DW'(count_o), 0);

    // Stall with back-pressure.
    in_valid_i = 1'b1; in_data_i = 32'h11; out_ready_i = 1'b1;
    step();
    in_data_i = 32'h22; out_ready_i = 1'b0;
    #1;
    chk("stall_in_ready_pre", DW'(in_ready_o), DW'(SKID));
    step();
    chk("stall_count", DW'(count_o), SKID ? 2 : 1);
    chk("stall_data", out_data_o, 32'h11);
    chk("stall_in_ready", DW'(in_ready_o), 0);
    if (SKID) in_valid_i = 1'b0;
    step();
    chk("stall_hold_data", out_data_o, 32'h11);
    chk("stall_hold_count", DW'(count_o), SKID ? 2 : 1);
    out_ready_i = 1'b1;
    step();
    chk("unstall_data", out_data_o, 32'h22);
    chk("unstall_count", DW'(count_o), 1);
    in_valid_i = 1'b0;
    step();
    chk("unstall_empty", DW'(count_o), 0);

    // Flush with a full stage and a same-cycle offer.
    out_ready_i = 1'b0; in_valid_i = 1'b1; in_data_i = 32'h44;
    step();
    in_data_i = 32'h55;
    step();
    chk("flush_fill_count", DW'(count_o), SKID ? 2 : 1);
    flush_i = 1'b1; in_data_i = 32'h33;
    step();
    flush_i = 1'b0; in_valid_i = 1'b0;
    #1;
    chk("flush_valid", DW'(out_valid_o), 0);
    chk("flush_count", DW'(count_o), 0);
    chk("flush_in_ready", DW'(in_ready_o), 1);
    out_ready_i = 1'b1;
    step();
    step();
    chk("flush_no_ghost", DW'(out_valid_o), 0);

    // Reset while stalled.
    out_ready_i = 1'b0; in_valid_i = 1'b1; in_data_i = 32'h66;
    step();
    in_data_i = 32'h77;
    step();
    chk("rstmid_fill_count", DW'(count_o), SKID ? 2 : 1);
    rst = 1'b1;
    #1;
    chk("rstmid_in_ready_during", DW'(in_ready_o), 0);
    step();
    chk("rstmid_valid", DW'(out_valid_o), 0);
    chk("rstmid_data", out_data_o, TB_RST);
    chk("rstmid_count", DW'(count_o), 0);
    rst = 1'b0; in_valid_i = 1'b0;
    #1;
    chk("rstmid_in_ready_after", DW'(in_ready_o), 1);

    // Random traffic; the model checks every cycle.
    for (int i = 0; i < 10000; i++) begin
      in_valid_i  = 1'($urandom_range(0, 1));
      in_data_i   = $urandom;
      out_ready_i = 1'($urandom_range(0, 1));
      step();
    end
    in_valid_i = 1'b0; out_ready_i = 1'b1;
    step(); step(); step();
    chk("final_drain_count", DW'(count_o), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
